// File: rtl/exe_stage_md_if.sv
// Decode -> execute -> memory handshake and datapath bundle for exe_stage_md.
// The master side is the surrounding pipeline; the slave side is the execute stage.
interface exe_stage_md_if #(
  parameter int DATA_W = 32
);
  logic              ms_allowin;
  logic              es_allowin;
  logic              ds_to_es_valid;
  logic [3:0]        ds_op;
  logic [DATA_W-1:0] ds_src1;
  logic [DATA_W-1:0] ds_src2;
  logic [4:0]        ds_dest;
  logic              ds_gr_we;
  logic [31:0]       ds_pc;
  logic              es_flush;
  logic              es_to_ms_valid;
  logic [DATA_W-1:0] es_result;
  logic [4:0]        es_dest;
  logic              es_gr_we;
  logic [31:0]       es_pc;
  logic              es_md_busy;

  modport master (
    output ms_allowin, ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_dest, ds_gr_we,
           ds_pc, es_flush,
    input  es_allowin, es_to_ms_valid, es_result, es_dest, es_gr_we, es_pc, es_md_busy
  );

  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_dest, ds_gr_we,
           ds_pc, es_flush,
    output es_allowin, es_to_ms_valid, es_result, es_dest, es_gr_we, es_pc, es_md_busy
  );
endinterface

// File: rtl/exe_stage_md.sv
// Execute stage with multi-cycle multiply/divide, HI/LO registers and flush.
// Optional macro EXE_DIV_ZERO_FAST_EN: divide by zero skips the iteration loop.
module exe_stage_md #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input logic          clk,
  input logic          reset,
  exe_stage_md_if.slave bus
);
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W  = $clog2(MUL_LAT + 1);
  localparam int DCNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  MUL_DONE  = CNT_W'(MUL_LAT);
  localparam logic [DCNT_W-1:0] DIV_ITERS = DCNT_W'(DATA_W);

  // pipeline registers
  logic              es_valid;
  logic [3:0]        es_op;
  logic [DATA_W-1:0] es_src1, es_src2;
  logic [4:0]        es_dest_r;
  logic              es_gr_we_r;
  logic [31:0]       es_pc_r;

  logic [DATA_W-1:0] hi, lo;
  logic [CNT_W-1:0]  mul_cnt;

  logic [1:0]        div_state;
  logic [DCNT_W-1:0] div_cnt;
  logic [DATA_W:0]   div_a;
  logic [DATA_W-1:0] div_q, div_d;
  logic              div_q_neg, div_r_neg;

  logic [3:0] ds_op_norm;
  logic       ds_is_mul, is_mul, is_div, is_sdiv;
  logic       es_ready_go, es_allowin, es_fire, ds_accept;

  assign ds_op_norm = (bus.ds_op > OP_MTLO) ? OP_ADD : bus.ds_op;
  assign ds_is_mul  = (ds_op_norm == OP_MULT) || (ds_op_norm == OP_MULTU);
  assign is_mul     = (es_op == OP_MULT) || (es_op == OP_MULTU);
  assign is_div     = (es_op == OP_DIV)  || (es_op == OP_DIVU);
  assign is_sdiv    = (es_op == OP_DIV);

  always_comb begin
    es_ready_go = 1'b1;
    if (is_mul)      es_ready_go = (mul_cnt == MUL_DONE);
    else if (is_div) es_ready_go = (div_state == S_DONE);
  end

  assign es_allowin         = !es_valid || (es_ready_go && bus.ms_allowin);
  assign bus.es_allowin     = es_allowin;
  assign bus.es_to_ms_valid = es_valid && es_ready_go && !bus.es_flush;
  assign es_fire            = bus.es_to_ms_valid && bus.ms_allowin;
  assign ds_accept          = bus.ds_to_es_valid && es_allowin;

  // one 2W-bit multiplier; sign-extending the operands gives the signed product
  logic [2*DATA_W-1:0] mul_a, mul_b, product;
  assign mul_a   = {{DATA_W{(es_op == OP_MULT) && es_src1[DATA_W-1]}}, es_src1};
  assign mul_b   = {{DATA_W{(es_op == OP_MULT) && es_src2[DATA_W-1]}}, es_src2};
  assign product = mul_a * mul_b;

  // divider operand conditioning and one restoring step
  logic              src1_neg, src2_neg, div_zero, div_take;
  logic [DATA_W-1:0] abs1, abs2, quot, rem, rem_raw;
  logic [DATA_W:0]   div_shift, div_trial;

  assign src1_neg  = is_sdiv && es_src1[DATA_W-1];
  assign src2_neg  = is_sdiv && es_src2[DATA_W-1];
  assign abs1      = src1_neg ? -es_src1 : es_src1;
  assign abs2      = src2_neg ? -es_src2 : es_src2;
  assign div_zero  = (es_src2 == '0);
  assign div_shift = {div_a[DATA_W-1:0], div_q[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, div_d};
  assign div_take  = !div_trial[DATA_W];
  assign rem_raw   = div_a[DATA_W-1:0];

  // zero divisor bypasses sign correction: all-ones quotient, raw dividend remainder
  always_comb begin
    quot = div_q_neg ? -div_q : div_q;
    rem  = div_r_neg ? -rem_raw : rem_raw;
    if (div_zero) begin
      quot = '1;
      rem  = es_src1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      es_valid <= 1'b0;
    end else if (bus.es_flush) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= bus.ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      es_op      <= OP_ADD;
      es_src1    <= '0;
      es_src2    <= '0;
      es_dest_r  <= '0;
      es_gr_we_r <= 1'b0;
      es_pc_r    <= '0;
    end else if (ds_accept) begin
      es_op      <= ds_op_norm;
      es_src1    <= bus.ds_src1;
      es_src2    <= bus.ds_src2;
      es_dest_r  <= bus.ds_dest;
      es_gr_we_r <= bus.ds_gr_we;
      es_pc_r    <= bus.ds_pc;
    end
  end

  // counter restarts at 1 only when a multiply actually enters the stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt <= '0;
    end else if (bus.es_flush) begin
      mul_cnt <= '0;
    end else if (!es_valid || es_fire) begin
      mul_cnt <= (ds_accept && ds_is_mul) ? CNT_W'(1) : '0;
    end else if (mul_cnt != '0 && mul_cnt != MUL_DONE) begin
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_state <= S_IDLE;
      div_cnt   <= '0;
      div_a     <= '0;
      div_q     <= '0;
      div_d     <= '0;
      div_q_neg <= 1'b0;
      div_r_neg <= 1'b0;
    end else if (bus.es_flush) begin
      div_state <= S_IDLE;
    end else begin
      case (div_state)
        S_IDLE: begin
          if (es_valid && is_div) begin
            div_a     <= '0;
            div_q     <= abs1;
            div_d     <= abs2;
            div_cnt   <= DIV_ITERS;
            div_q_neg <= src1_neg ^ src2_neg;
            div_r_neg <= src1_neg;
`ifdef EXE_DIV_ZERO_FAST_EN
            div_state <= div_zero ? S_DONE : S_BUSY;
`else
            div_state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          div_a   <= div_take ? div_trial : div_shift;
          div_q   <= {div_q[DATA_W-2:0], div_take};
          div_cnt <= div_cnt - 1'b1;
          if (div_cnt == DCNT_W'(1)) div_state <= S_DONE;
        end
        S_DONE: begin
          if (es_fire) div_state <= S_IDLE;
        end
        default: div_state <= S_IDLE;
      endcase
    end
  end

  // architectural HI/LO change only on the retiring edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (es_fire) begin
      case (es_op)
        OP_MULT, OP_MULTU: {hi, lo} <= product;
        OP_DIV, OP_DIVU: begin
          lo <= quot;
          hi <= rem;
        end
        OP_MTHI: hi <= es_src1;
        OP_MTLO: lo <= es_src1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (es_op)
      OP_ADD:  bus.es_result = es_src1 + es_src2;
      OP_MFHI: bus.es_result = hi;
      OP_MFLO: bus.es_result = lo;
      default: bus.es_result = '0;
    endcase
  end

  assign bus.es_dest    = es_dest_r;
  assign bus.es_gr_we   = es_gr_we_r;
  assign bus.es_pc      = es_pc_r;
  assign bus.es_md_busy = (mul_cnt != '0) || (div_state != S_IDLE);
endmodule

// File: tb/tb_exe_stage_md.sv
// Scoreboard bench for exe_stage_md: expected results queued at issue, popped at retire.
module tb_exe_stage_md;
  localparam int W  = 32;
  localparam int ML = 2;
`ifdef EXE_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = W + 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  exe_stage_md_if #(.DATA_W(W)) bus();
  exe_stage_md #(.DATA_W(W), .MUL_LAT(ML)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  dest;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi = 0, m_lo = 0, pc_ctr = 32'h100;
  int          n_chk = 0, n_pass = 0;

  task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [4:0] dest);
    exp_t e;
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    logic signed [31:0] ia, ib;
    e.pc = pc; e.dest = dest; e.res = 0;
    ia = a; ib = b;
    case (op)
      4'd1: begin sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; sp = sa * sb;
                  m_hi = sp[63:32]; m_lo = sp[31:0]; end
      4'd2: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = ia / ib; m_hi = ia % ib; end
      4'd4: if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
      4'd5: e.res = m_hi;
      4'd6: e.res = m_lo;
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: e.res = a + b;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    pc_ctr = pc_ctr + 4;
    bus.ds_op = op; bus.ds_src1 = a; bus.ds_src2 = b;
    bus.ds_dest = pc_ctr[6:2]; bus.ds_gr_we = 1'b1; bus.ds_pc = pc_ctr;
    bus.ds_to_es_valid = 1'b1;
    if (push) predict(op, a, b, pc_ctr, pc_ctr[6:2]);
  endtask

  // issue one instruction into an empty stage, retire it and score it; lat = cycle of fire
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    exp_t e;
    int n;
    lat = -1;
    drive(op, a, b, 1);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    for (n = 1; n <= 200; n++) begin
      if (bus.es_to_ms_valid && bus.ms_allowin) break;
      @(posedge clk); #1;
    end
    n_chk++;
    if (n > 200) begin
      $display("FAIL retire_timeout op=%0d: no fire in 200 cycles, required a fire", op);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      lat = n;
      e = exp_q.pop_front();
      if (bus.es_result !== e.res || bus.es_pc !== e.pc || bus.es_dest !== e.dest)
        $display("FAIL retire op=%0d: got res=%h pc=%h dest=%0d, required res=%h pc=%h dest=%0d",
                 op, bus.es_result, bus.es_pc, bus.es_dest, e.res, e.pc, e.dest);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (bus.es_allowin !== 1'b1) $display("FAIL rst_allowin: got %b required 1", bus.es_allowin); else n_pass++;
    n_chk++; if (bus.es_to_ms_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", bus.es_to_ms_valid); else n_pass++;
    n_chk++; if (bus.es_result !== 32'h0) $display("FAIL rst_result: got %h required 0", bus.es_result); else n_pass++;
    n_chk++; if (bus.es_md_busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", bus.es_md_busy); else n_pass++;
    #20 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat;
    run_op(4'd0, 32'hFFFF_FFFF, 32'h2, lat);
    n_chk++; if (lat !== 1) $display("FAIL add_latency: got %0d required 1", lat); else n_pass++;
    run_op(4'd13, 32'h10, 32'h20, lat);
    run_op(4'd8, 32'h1234, 32'h0, lat);
    run_op(4'd6, 32'h0, 32'h0, lat);
  endtask

  task automatic test_mult;
    int lat;
    exp_t e;
    drive(4'd1, 32'hFFFF_FFFE, 32'h3, 1);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    n_chk++; if (bus.es_allowin !== 1'b0 || bus.es_md_busy !== 1'b1 || bus.es_to_ms_valid !== 1'b0)
      $display("FAIL mult_cycle1: got allowin=%b busy=%b valid=%b required 0 1 0",
               bus.es_allowin, bus.es_md_busy, bus.es_to_ms_valid);
    else n_pass++;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_chk++; if (bus.es_to_ms_valid !== 1'b1 || bus.es_result !== e.res)
      $display("FAIL mult_cycle2: got valid=%b res=%h required 1 %h", bus.es_to_ms_valid, bus.es_result, e.res);
    else n_pass++;
    @(posedge clk); #1;
    run_op(4'd5, 0, 0, lat);
    run_op(4'd6, 0, 0, lat);
    run_op(4'd2, 32'hFFFF_FFFE, 32'h3, lat);
    n_chk++; if (lat !== ML) $display("FAIL multu_latency: got %0d required %0d", lat, ML); else n_pass++;
    run_op(4'd5, 0, 0, lat);
    run_op(4'd6, 0, 0, lat);
  endtask

  task automatic test_div;
    int lat;
    run_op(4'd3, 32'hFFFF_FFF9, 32'h2, lat);
    n_chk++; if (lat !== W + 2) $display("FAIL div_latency: got %0d required %0d", lat, W + 2); else n_pass++;
    run_op(4'd6, 0, 0, lat);
    run_op(4'd5, 0, 0, lat);
    run_op(4'd4, 32'h7, 32'h2, lat);
    run_op(4'd6, 0, 0, lat);
    run_op(4'd5, 0, 0, lat);
    run_op(4'd3, 32'h7, 32'hFFFF_FFFE, lat);
    run_op(4'd6, 0, 0, lat);
    run_op(4'd5, 0, 0, lat);
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(4'd4, 32'h5, 32'h0, lat);
    n_chk++; if (lat !== DZ_LAT) $display("FAIL divz_latency: got %0d required %0d", lat, DZ_LAT); else n_pass++;
    run_op(4'd6, 0, 0, lat);
    run_op(4'd5, 0, 0, lat);
    run_op(4'd3, 32'hFFFF_FFFB, 32'h0, lat);
    run_op(4'd6, 0, 0, lat);
    run_op(4'd5, 0, 0, lat);
  endtask

  task automatic test_flush;
    int lat, seen;
    seen = 0;
    drive(4'd3, 32'd100, 32'd7, 0);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (bus.es_to_ms_valid) seen++;
      @(posedge clk); #1;
    end
    bus.es_flush = 1'b1;
    #1;
    if (bus.es_to_ms_valid) seen++;
    @(posedge clk); #1;
    bus.es_flush = 1'b0;
    n_chk++; if (bus.es_md_busy !== 1'b0 || bus.es_allowin !== 1'b1)
      $display("FAIL flush_idle: got busy=%b allowin=%b required 0 1", bus.es_md_busy, bus.es_allowin);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (bus.es_to_ms_valid) seen++;
      @(posedge clk); #1;
    end
    n_chk++; if (seen !== 0) $display("FAIL flush_no_fire: got %0d fires required 0", seen); else n_pass++;
    run_op(4'd5, 0, 0, lat);
    run_op(4'd6, 0, 0, lat);
    run_op(4'd0, 32'h55, 32'h11, lat);
    // instruction offered during a flush must be dropped
    drive(4'd0, 32'h1, 32'h1, 0);
    bus.es_flush = 1'b1;
    @(posedge clk); #1;
    bus.es_flush = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    n_chk++; if (bus.es_to_ms_valid !== 1'b0 || bus.es_allowin !== 1'b1)
      $display("FAIL flush_drop: got valid=%b allowin=%b required 0 1", bus.es_to_ms_valid, bus.es_allowin);
    else n_pass++;
  endtask

  task automatic test_hold;
    int lat, n, bad;
    exp_t e;
    bad = 0;
    bus.ms_allowin = 1'b0;
    drive(4'd3, 32'hFFFF_FF9C, 32'd7, 1);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    for (n = 1; n <= 60; n++) begin
      if (bus.es_to_ms_valid) break;
      @(posedge clk); #1;
    end
    n_chk++; if (n !== W + 2) $display("FAIL hold_ready: got cycle %0d required %0d", n, W + 2); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.es_to_ms_valid !== 1'b1 || bus.es_result !== 32'h0 || bus.es_allowin !== 1'b0 ||
          bus.es_md_busy !== 1'b1) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); else n_pass++;
    bus.ms_allowin = 1'b1;
    #1;
    e = exp_q.pop_front();
    n_chk++; if (bus.es_to_ms_valid !== 1'b1 || bus.es_pc !== e.pc)
      $display("FAIL hold_release: got valid=%b pc=%h required 1 %h", bus.es_to_ms_valid, bus.es_pc, e.pc);
    else n_pass++;
    @(posedge clk); #1;
    run_op(4'd6, 0, 0, lat);
    run_op(4'd5, 0, 0, lat);
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops[5];
    logic [31:0] as[5];
    exp_t e;
    ops = '{4'd7, 4'd5, 4'd0, 4'd8, 4'd6};
    as  = '{32'hA5A5_0001, 32'h0, 32'h3, 32'h77, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], 32'h4, 1);
      @(posedge clk); #1;
      if (i == 4) bus.ds_to_es_valid = 1'b0;
      e = exp_q.pop_front();
      n_chk++; if (bus.es_to_ms_valid !== 1'b1 || bus.es_result !== e.res || bus.es_pc !== e.pc)
        $display("FAIL b2b_%0d: got valid=%b res=%h pc=%h required 1 %h %h",
                 i, bus.es_to_ms_valid, bus.es_result, bus.es_pc, e.res, e.pc);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    drive(4'd3, 32'h1000, 32'h3, 0);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    n_chk++; if (bus.es_md_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", bus.es_md_busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (bus.es_md_busy !== 1'b0 || bus.es_allowin !== 1'b1 || bus.es_to_ms_valid !== 1'b0 ||
                 bus.es_result !== 32'h0 || bus.es_pc !== 32'h0)
      $display("FAIL midrst_outputs: got busy=%b allowin=%b valid=%b res=%h pc=%h required 0 1 0 0 0",
               bus.es_md_busy, bus.es_allowin, bus.es_to_ms_valid, bus.es_result, bus.es_pc);
    else n_pass++;
    #2 reset = 1'b1;
    m_hi = 0; m_lo = 0;
    exp_q.delete();
    @(posedge clk); #1;
    run_op(4'd5, 0, 0, lat);
    run_op(4'd6, 0, 0, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.ms_allowin = 1'b1; bus.ds_to_es_valid = 1'b0; bus.es_flush = 1'b0;
    bus.ds_op = 0; bus.ds_src1 = 0; bus.ds_src2 = 0; bus.ds_dest = 0; bus.ds_gr_we = 0; bus.ds_pc = 0;
    test_reset;
    test_add;
    test_mult;
    test_div;
    test_div_zero;
    test_flush;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exe_stage_md.md
Name: exe_stage_md

Overview:
- Parametrised execute stage for the in-order MIPS pipeline. It sits between decode and memory and uses the same valid/allowin handshake as the other stages.
- Adds multi-cycle multiply/divide with architectural HI/LO registers.
- Adds a flush input so the exception logic can kill the in-flight instruction.
- Stalls `es_allowin` while a multiply or divide is pending.

Parameters:
- DATA_W, 32: operand, result and HI/LO width. Must be even and at least 8.
- MUL_LAT, 2: cycles a MULT/MULTU occupies the stage. Must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset. The block is in reset while `reset` = 0.
- ms_allowin  in  1  memory stage can accept.
- es_allowin  out  1  stage can accept from decode.
- ds_to_es_valid  in  1  decode output valid.
- ds_op  in  4  operation: 0 ADD, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9-15 behave as ADD.
- ds_src1  in  DATA_W  operand 1 (rs).
- ds_src2  in  DATA_W  operand 2 (rt/imm).
- ds_dest  in  5  destination register.
- ds_gr_we  in  1  register write enable.
- ds_pc  in  32  PC.
- es_flush  in  1  kill the instruction currently in the stage (exception/eret).
- es_to_ms_valid  out  1  result valid toward memory stage.
- es_result  out  DATA_W  ADD sum, or HI/LO for MFHI/MFLO, otherwise 0.
- es_dest  out  5  registered ds_dest.
- es_gr_we  out  1  registered ds_gr_we.
- es_pc  out  32  registered ds_pc.
- es_md_busy  out  1  multiplier counter or divider FSM not idle.

Behaviour:
- Reset values:
  - es_valid=0, HI=0, LO=0, divider FSM=IDLE, mul counter=0, all pipeline registers 0.
  - Outputs under reset: es_allowin=1, es_to_ms_valid=0, es_result=0, es_md_busy=0.
- Handshake:
  - `es_allowin = !es_valid || (es_ready_go && ms_allowin)`.
  - `es_to_ms_valid = es_valid && es_ready_go && !es_flush`.
  - Fields are latched only when `ds_to_es_valid && es_allowin`.
- Flush:
  - If es_flush=1, es_valid clears next edge and the divider FSM and mul counter return to idle next edge.
  - HI/LO are not written by the killed instruction.
  - If a new instruction is offered in the same cycle as es_flush, it is dropped (es_valid=0).
- Single-cycle ops: ADD, MFHI, MFLO, MTHI, MTLO have es_ready_go=1 on the first cycle.
  - ADD result is `src1+src2` modulo 2^DATA_W, with no overflow trap.
- MULT/MULTU:
  - The product is 2*DATA_W bits: signed for MULT, unsigned for MULTU.
  - The mul counter starts at 1 on entry and es_ready_go=1 when the count equals MUL_LAT.
  - The result is held while ms_allowin=0.
- DIV/DIVU FSM:
  - IDLE→BUSY on the first valid cycle: load |dividend|, |divisor|, sign flags, and iteration count = DATA_W.
  - BUSY runs one restoring-division iteration per cycle. After DATA_W iterations it moves to DONE.
  - DONE: es_ready_go=1. DONE→IDLE on fire (es_to_ms_valid && ms_allowin).
  - With ms_allowin constant 1, occupancy is DATA_W+2 cycles.
  - Signed correction: quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
  - Divisor=0: quotient = all ones and remainder = dividend for both signedness modes. There is no sign correction.
- HI/LO write: performed on the fire edge only, never during the stall.
  - MULT/MULTU: {HI,LO} = product.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - MTHI: HI = src1.
  - MTLO: LO = src1.
  - A following MFHI/MFLO therefore sees the updated value without forwarding.
- es_md_busy: 1 while mul count is at least 1 or FSM is not IDLE.
- Asynchronous reset mid-divide returns the FSM to IDLE immediately.

Optional Feature:
- Macro EXE_DIV_ZERO_FAST_EN.
- Defined: a divide with divisor=0 goes IDLE→DONE directly (occupancy 2 cycles) with the same quotient/remainder values.
- Undefined: it runs the full DATA_W iterations.

Test Plan:
- DATA_W=32, ms_allowin=1: ADD 0xFFFFFFFF + 2 → es_result=1 and es_to_ms_valid on the first cycle. Then MTLO 0x1234, then MFLO → es_result=0x1234.
- MULT src1=0xFFFFFFFE (-2), src2=3, MUL_LAT=2 → es_allowin=0 for one cycle, fire on cycle 2. Then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7/2 → fire exactly 34 cycles after entry, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. Fire at 34 cycles without the macro, 2 cycles with EXE_DIV_ZERO_FAST_EN.
- DIV in flight with es_flush pulsed at cycle 10 → es_to_ms_valid never asserts, HI/LO unchanged, es_md_busy=0 next cycle. The next ADD completes normally.
- DIV held in DONE with ms_allowin=0 for 5 cycles → es_result stable, HI/LO unchanged until the fire edge. Asserting reset=0 mid-BUSY → all outputs at reset values immediately.
